// File: rtl/prach_pkg.sv
// Shared definitions for the PRACH radix-3 DIT FFT datapath.
//   PRACH_DW         default real/imag data width
//   PRACH_CW         default coefficient width (Q1.(CW-1))
//   PRACH_C_SQRT3_2  sqrt(3)/2 in Q1.17
//   phase_e          position of a sample inside a serial triple
//   prach_sat        clip a DW+2 value to DW bits, flags clipping
//   prach_sext2      sign-extend a DW value to DW+2 bits
package prach_pkg;

  localparam int PRACH_DW        = 18;
  localparam int PRACH_CW        = 18;
  localparam int PRACH_C_SQRT3_2 = 113512;

  typedef enum logic [1:0] {
    PH_A0 = 2'd0,
    PH_A1 = 2'd1,
    PH_A2 = 2'd2
  } phase_e;

  typedef struct packed {
    logic                clip;
    logic [PRACH_DW-1:0] val;
  } prach_sat_t;

  // In range exactly when the top three bits agree.
  function automatic prach_sat_t prach_sat(input logic [PRACH_DW+1:0] x);
    prach_sat_t s;
    s.clip = !((x[PRACH_DW+1:PRACH_DW-1] == 3'b000) ||
               (x[PRACH_DW+1:PRACH_DW-1] == 3'b111));
    if (!s.clip)
      s.val = x[PRACH_DW-1:0];
    else if (x[PRACH_DW+1])
      s.val = {1'b1, {(PRACH_DW-1){1'b0}}};
    else
      s.val = {1'b0, {(PRACH_DW-1){1'b1}}};
    return s;
  endfunction

  function automatic logic [PRACH_DW+1:0] prach_sext2(input logic [PRACH_DW-1:0] x);
    return {{2{x[PRACH_DW-1]}}, x};
  endfunction

endpackage

// File: rtl/prach_ditfft3_bf3_combine_delay.sv
// Fixed-latency shift register with asynchronous active-low clear.
//   clk, rst_n  clock / async active-low reset
//   i_din       WIDTH-bit input
//   o_dout      i_din delayed by DELAY clocks
module prach_ditfft3_bf3_combine_delay #(
  parameter int WIDTH = 2,
  parameter int DELAY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_sr [DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DELAY; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_din;
      for (int unsigned k = 1; k < DELAY; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_dout = r_sr[DELAY-1];

endmodule

// File: rtl/prach_ditfft3_bf3_combine.sv
// Radix-3 DIT FFT butterfly, final combine stage.
// Serial input triple a0=x0, a1=x1+x2, a2=x1-x2; serial output triple
// X0=a0+a1, X1=m+(-j)t, X2=m+(j)t with m=a0-a1/2, t=(sqrt3/2)*a2.
// Fixed latency of 4 clocks per sample.
//   clk, rst_n         clock / async active-low reset
//   din_dr/di/dv       input sample (complex) and valid
//   sync_in            marks a0 (qualified by din_dv)
//   dout_dr/di/dv      output sample and valid
//   sync_out           marks X0
//   ovf                output sample was saturated
module prach_ditfft3_bf3_combine
  import prach_pkg::*;
#(
  parameter int DW   = PRACH_DW,
  parameter int CW   = PRACH_CW,
  parameter int COEF = PRACH_C_SQRT3_2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_dr,
  input  logic [DW-1:0] din_di,
  input  logic          din_dv,
  input  logic          sync_in,
  output logic [DW-1:0] dout_dr,
  output logic [DW-1:0] dout_di,
  output logic          dout_dv,
  output logic          sync_out,
  output logic          ovf
);

  localparam logic signed [DW+CW-1:0] C_COEF = (DW+CW)'(COEF);
  localparam logic signed [DW+CW-1:0] C_RND  = {{(DW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};

  phase_e r_cnt, w_cnt_nxt, w_ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= PH_A0;
    else        r_cnt <= w_cnt_nxt;
  end

  always_comb begin
    w_ph      = sync_in ? PH_A0 : r_cnt;
    w_cnt_nxt = r_cnt;
    if (din_dv) begin
      unique case (w_ph)
        PH_A0:   w_cnt_nxt = PH_A1;
        PH_A1:   w_cnt_nxt = PH_A2;
        default: w_cnt_nxt = PH_A0;
      endcase
    end
  end

  // Phase tag follows each sample so the output stage knows which of
  // X0/X1/X2 to emit three clocks after capture.
  logic   r_s1_v, r_s2_v, r_s3_v;
  phase_e r_s1_ph, r_s2_ph, r_s3_ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v  <= 1'b0;
      r_s2_v  <= 1'b0;
      r_s3_v  <= 1'b0;
      r_s1_ph <= PH_A0;
      r_s2_ph <= PH_A0;
      r_s3_ph <= PH_A0;
    end else begin
      r_s1_v  <= din_dv;
      r_s2_v  <= r_s1_v;
      r_s3_v  <= r_s2_v;
      r_s1_ph <= w_ph;
      r_s2_ph <= r_s1_ph;
      r_s3_ph <= r_s2_ph;
    end
  end

  logic        [DW-1:0]    r_a0_r, r_a0_i, r_a1_r, r_a1_i;
  logic signed [DW+CW-1:0] r_prod_r, r_prod_i;
  logic signed [DW+1:0]    r_x0_r, r_x0_i, r_m_r, r_m_i, r_t_r, r_t_i;
  logic signed [DW+1:0]    w_a0_r, w_a0_i, w_a1_r, w_a1_i, w_t_r, w_t_i;
  logic signed [DW+CW-1:0] w_din_r_x, w_din_i_x;

  assign w_a0_r    = prach_sext2(r_a0_r);
  assign w_a0_i    = prach_sext2(r_a0_i);
  assign w_a1_r    = prach_sext2(r_a1_r);
  assign w_a1_i    = prach_sext2(r_a1_i);
  assign w_din_r_x = {{CW{din_dr[DW-1]}}, din_dr};
  assign w_din_i_x = {{CW{din_di[DW-1]}}, din_di};
  assign w_t_r     = (DW+2)'((r_prod_r + C_RND) >>> (CW-1));
  assign w_t_i     = (DW+2)'((r_prod_i + C_RND) >>> (CW-1));

  // x0/m are formed one clock after a1 is captured and t one clock after
  // the product, so both stay stable until X2 of the same triple has been
  // emitted even when the next triple follows back-to-back.
  always_ff @(posedge clk) begin
    if (din_dv && w_ph == PH_A0) begin
      r_a0_r <= din_dr;
      r_a0_i <= din_di;
    end
    if (din_dv && w_ph == PH_A1) begin
      r_a1_r <= din_dr;
      r_a1_i <= din_di;
    end
    if (din_dv && w_ph == PH_A2) begin
      r_prod_r <= w_din_r_x * C_COEF;
      r_prod_i <= w_din_i_x * C_COEF;
    end
    if (r_s1_v && r_s1_ph == PH_A1) begin
      r_x0_r <= w_a0_r + w_a1_r;
      r_x0_i <= w_a0_i + w_a1_i;
      r_m_r  <= w_a0_r - (w_a1_r >>> 1);
      r_m_i  <= w_a0_i - (w_a1_i >>> 1);
    end
    if (r_s1_v && r_s1_ph == PH_A2) begin
      r_t_r <= w_t_r;
      r_t_i <= w_t_i;
    end
  end

  logic signed [DW+1:0] w_pre_r, w_pre_i;
  prach_sat_t           w_sat_r, w_sat_i;

  always_comb begin
    w_pre_r = r_x0_r;
    w_pre_i = r_x0_i;
    unique case (r_s3_ph)
      PH_A1: begin
        w_pre_r = r_m_r + r_t_i;
        w_pre_i = r_m_i - r_t_r;
      end
      PH_A2: begin
        w_pre_r = r_m_r - r_t_i;
        w_pre_i = r_m_i + r_t_r;
      end
      default: ;
    endcase
    w_sat_r = prach_sat(w_pre_r);
    w_sat_i = prach_sat(w_pre_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dr <= '0;
      dout_di <= '0;
      ovf     <= 1'b0;
    end else if (r_s3_v) begin
      dout_dr <= w_sat_r.val;
      dout_di <= w_sat_i.val;
      ovf     <= w_sat_r.clip | w_sat_i.clip;
    end else begin
      ovf     <= 1'b0;
    end
  end

  prach_ditfft3_bf3_combine_delay #(
    .WIDTH(2),
    .DELAY(4)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_din ({sync_in, din_dv}),
    .o_dout({sync_out, dout_dv})
  );

endmodule

// File: tb/tb_prach_ditfft3_bf3_combine.sv
module tb_prach_ditfft3_bf3_combine;

  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din_dr = '0, din_di = '0;
  logic          din_dv = 1'b0, sync_in = 1'b0;
  logic [DW-1:0] dout_dr, dout_di;
  logic          dout_dv, sync_out, ovf;

  always #5 clk = ~clk;

  prach_ditfft3_bf3_combine #(
    .DW  (DW),
    .CW  (18),
    .COEF(113512)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_dr  (din_dr),
    .din_di  (din_di),
    .din_dv  (din_dv),
    .sync_in (sync_in),
    .dout_dr (dout_dr),
    .dout_di (dout_di),
    .dout_dv (dout_dv),
    .sync_out(sync_out),
    .ovf     (ovf)
  );

  typedef struct {
    int a0r, a0i, a1r, a1i, a2r, a2i;
    int x0r, x0i, x1r, x1i, x2r, x2i;
    bit ov0, ov1, ov2;
  } vec_t;

  typedef struct {
    bit care;
    int r;
    int i;
    bit ov;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] hist [4];
  bit         last_known = 1'b1;
  int         last_r = 0, last_i = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input longint x, output bit c);
    c = 1'b0;
    if (x > 131071) begin c = 1'b1; return 131071; end
    if (x < -131072) begin c = 1'b1; return -131072; end
    return int'(x);
  endfunction

  function automatic vec_t model(input int a0r, a0i, a1r, a1i, a2r, a2i);
    vec_t   v;
    longint mr, mi, tr, ti;
    bit     c1, c2;
    v.a0r = a0r; v.a0i = a0i; v.a1r = a1r; v.a1i = a1i; v.a2r = a2r; v.a2i = a2i;
    mr = longint'(a0r) - longint'(a1r >>> 1);
    mi = longint'(a0i) - longint'(a1i >>> 1);
    tr = (longint'(113512) * a2r + 65536) >>> 17;
    ti = (longint'(113512) * a2i + 65536) >>> 17;
    v.x0r = sat(longint'(a0r) + a1r, c1); v.x0i = sat(longint'(a0i) + a1i, c2); v.ov0 = c1 | c2;
    v.x1r = sat(mr + ti, c1);             v.x1i = sat(mi - tr, c2);             v.ov1 = c1 | c2;
    v.x2r = sat(mr - ti, c1);             v.x2i = sat(mi + tr, c2);             v.ov2 = c1 | c2;
    return v;
  endfunction

  // Reference for dout_dv/sync_out: inputs delayed four clocks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) hist[k] <= 2'b00;
    end else begin
      hist[0] <= {sync_in, din_dv};
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("dout_dv", dout_dv, hist[3][0]);
    chk("sync_out", sync_out, hist[3][1]);
    if (dout_dv) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_level", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        if (e.care) begin
          chk("dout_dr", longint'($signed(dout_dr)), e.r);
          chk("dout_di", longint'($signed(dout_di)), e.i);
          chk("ovf", ovf, e.ov);
        end
        last_known = e.care;
        last_r     = e.r;
        last_i     = e.i;
      end
    end else begin
      chk("ovf_idle", ovf, 0);
      if (last_known) begin
        chk("hold_dr", longint'($signed(dout_dr)), last_r);
        chk("hold_di", longint'($signed(dout_di)), last_i);
      end
    end
  end

  task automatic put(input bit dv, input bit sy, input int r, input int i);
    din_dv  = dv;
    sync_in = sy;
    din_dr  = 18'(r);
    din_di  = 18'(i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 1'b0, 12345, -4321);
  endtask

  task automatic push(input bit care, input int r, input int i, input bit ov);
    exp_t e;
    e.care = care; e.r = r; e.i = i; e.ov = ov;
    exp_q.push_back(e);
  endtask

  task automatic send_vec(input vec_t v, input bit sy);
    push(1'b1, v.x0r, v.x0i, v.ov0);
    push(1'b1, v.x1r, v.x1i, v.ov1);
    push(1'b1, v.x2r, v.x2i, v.ov2);
    put(1'b1, sy,   v.a0r, v.a0i);
    put(1'b1, 1'b0, v.a1r, v.a1i);
    put(1'b1, 1'b0, v.a2r, v.a2i);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout_dr"}, dout_dr, 0);
    chk({tag, "_dout_di"}, dout_di, 0);
    chk({tag, "_dout_dv"}, dout_dv, 0);
    chk({tag, "_sync_out"}, sync_out, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1000, 0, 2000, 0, 0, 0,         3000, 0, 0, 0, 0, 0,               0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 1000,            0, 0, 866, 0, -866, 0,             0, 0, 0};
    tbl[2] = '{10, 0, -3, 0, 0, 0,             7, 0, 12, 0, 12, 0,                0, 0, 0};
    tbl[3] = '{131071, 0, 131071, 0, 0, 0,     131071, 0, 65536, 0, 65536, 0,     1, 0, 0};
    tbl[4] = '{-131072, 0, -131072, 0, 0, 0,   -131072, 0, -65536, 0, -65536, 0,  1, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 1000, 0,            0, 0, 0, -866, 0, 866,             0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 1, -1,              0, 0, -1, -1, 1, 1,                0, 0, 0};
    tbl[7] = '{131071, 131071, -131072, -131072, 131071, -131072,
               -1, -1, 83095, 83096, 131071, 131071,                              0, 0, 1};

    // Reset held while inputs toggle.
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) put(1'b1, 1'b1, 5000 + k, -7000);
    check_reset_outputs("in_reset");
    din_dv  = 1'b0;
    sync_in = 1'b0;
    rst_n   = 1'b1;
    idle(6);
    check_reset_outputs("after_release");

    // Directed table, back-to-back, 3 idle cycles after entry 3.
    for (int k = 0; k < 8; k++) begin
      send_vec(tbl[k], 1'b1);
      if (k == 3) idle(3);
    end
    idle(3);

    // Resync on the 2nd sample of a triple.
    push(1'b0, 0, 0, 1'b0);
    put(1'b1, 1'b1, 777, 888);
    send_vec(model(500, -200, 300, 100, -400, 250), 1'b1);
    // Resync on the 3rd sample of a triple.
    push(1'b0, 0, 0, 1'b0);
    push(1'b0, 0, 0, 1'b0);
    put(1'b1, 1'b1, -999, 111);
    put(1'b1, 1'b0, 222, -333);
    send_vec(model(-1500, 2500, 4000, -6000, 7000, 9000), 1'b1);
    idle(2);

    // Reset in the middle of traffic.
    send_vec(model(100, 200, 300, 400, 500, 600), 1'b1);
    put(1'b1, 1'b1, 42, 43);
    rst_n   = 1'b0;
    din_dv  = 1'b0;
    sync_in = 1'b0;
    exp_q.delete();
    last_known = 1'b1;
    last_r     = 0;
    last_i     = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // No sync after reset: phase starts at a0.
    send_vec(model(-3000, 1234, 5678, -91, 20000, -30000), 1'b0);
    idle(4);

    // Random continuous triples.
    for (int k = 0; k < 100; k++)
      send_vec(model(rnd18(), rnd18(), rnd18(), rnd18(), rnd18(), rnd18()), k == 0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    chk("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
